// File: rtl/pad_pkg.sv
// pad_pkg: shared state encoding, button bit positions and default timing for the pad sequencer
package pad_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;
  localparam int PHASE_CYCLES_DEF = 100;
  localparam int PERIOD_LOG2_DEF = 20;
  localparam int B_UP = 10;
  localparam int B_DOWN = 9;
  localparam int B_LEFT = 8;
  localparam int B_RIGHT = 7;
  localparam int B_A = 6;
  localparam int B_B = 5;
  localparam int B_C = 4;
  localparam int B_START = 3;
  localparam int B_X = 2;
  localparam int B_Y = 1;
  localparam int B_Z = 0;
endpackage

// File: rtl/pad_phase_timer.sv
// pad_phase_timer: holds each select half-phase for PHASE_CYCLES cycles and strobes its last cycle
module pad_phase_timer import pad_pkg::*; #(
  parameter int PHASE_CYCLES = PHASE_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  output logic [2:0] phase,
  output logic       sample,
  output logic       done
);
  localparam int CW = PHASE_CYCLES > 1 ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(PHASE_CYCLES - 1);
  logic [CW-1:0] cnt;
  assign sample = run && cnt == LAST;
  assign done = sample && phase == 3'd7;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= '0;
      phase <= '0;
    end else if (!run) begin
      cnt <= '0;
      phase <= '0;
    end else if (sample) begin
      cnt <= '0;
      phase <= phase + 3'd1;
    end else
      cnt <= cnt + 1'b1;
endmodule

// File: rtl/genesis_pad_sequencer.sv
// genesis_pad_sequencer: periodically or on request scans a Genesis pad and publishes its button map
module genesis_pad_sequencer import pad_pkg::*; #(
  parameter int PHASE_CYCLES = PHASE_CYCLES_DEF,
  parameter int PERIOD_LOG2 = PERIOD_LOG2_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        up_z,
  input  logic        down_y,
  input  logic        left_x,
  input  logic        right,
  input  logic        a_b,
  input  logic        start_c,
  input  logic        poll_req,
  output logic        select,
  output logic [10:0] buttons,
  output logic        pad_present,
  output logic        six_button,
  output logic        valid,
  output logic        busy
);
  state_t state, nstate;
  logic [PERIOD_LOG2-1:0] period;
  logic [10:0] cap;
  logic [2:0] phase;
  logic sample, done, pending, present, six, trig, start;
  pad_phase_timer #(.PHASE_CYCLES(PHASE_CYCLES)) u_timer (
    .clk(clk),
    .reset(reset),
    .run(state == SCAN),
    .phase(phase),
    .sample(sample),
    .done(done)
  );
  always_comb begin
    trig = poll_req || pending || &period;
    start = state == IDLE && trig;
    nstate = state == IDLE ? (trig ? SCAN : IDLE) :
             state == SCAN ? (done ? COMMIT : SCAN) : IDLE;
    select = state != SCAN || !phase[0];
    busy = state != IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      period <= '0;
      pending <= 1'b0;
    end else begin
      state <= nstate;
      period <= (state != IDLE || start) ? '0 : period + 1'b1;
      pending <= start ? 1'b0 : pending || (busy && poll_req);
    end
  // Each half-phase contributes a different subset of pins; all are inverted to active-high
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cap <= '0;
      present <= 1'b0;
      six <= 1'b0;
    end else if (start) begin
      cap <= '0;
      present <= 1'b0;
      six <= 1'b0;
    end else if (sample) begin
      if (phase == 3'd0) begin
        cap[B_UP] <= !up_z;
        cap[B_DOWN] <= !down_y;
        cap[B_LEFT] <= !left_x;
        cap[B_RIGHT] <= !right;
        cap[B_B] <= !a_b;
        cap[B_C] <= !start_c;
      end
      if (phase == 3'd1) begin
        cap[B_A] <= !a_b;
        cap[B_START] <= !start_c;
        present <= !left_x && !right;
      end
      if (phase == 3'd5)
        six <= !up_z && !down_y && !left_x && !right;
      if (phase == 3'd6) begin
        cap[B_Z] <= !up_z;
        cap[B_Y] <= !down_y;
        cap[B_X] <= !left_x;
      end
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      buttons <= '0;
      pad_present <= 1'b0;
      six_button <= 1'b0;
      valid <= 1'b0;
    end else begin
      valid <= state == COMMIT;
      if (state == COMMIT) begin
        buttons <= present ? (six ? cap : {cap[10:3], 3'b000}) : '0;
        pad_present <= present;
        six_button <= present && six;
      end
    end
endmodule

// File: tb/tb_genesis_pad_sequencer.sv
// tb_genesis_pad_sequencer: directed scenarios against a pad model whose pins follow select
module tb_genesis_pad_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic up_z, down_y, left_x, right, a_b, start_c;
  logic poll_req = 1'b0;
  logic select, pad_present, six_button, valid, busy;
  logic [10:0] buttons;
  int tests = 0;
  int fails = 0;
  int pad_type = 0;
  logic [10:0] held = '0;
  int low_n = 0;
  int hi_cnt = 0;
  logic sel_q = 1'b1;

  genesis_pad_sequencer #(.PHASE_CYCLES(4), .PERIOD_LOG2(8)) dut (
    .clk(clk), .reset(reset), .up_z(up_z), .down_y(down_y), .left_x(left_x),
    .right(right), .a_b(a_b), .start_c(start_c), .poll_req(poll_req),
    .select(select), .buttons(buttons), .pad_present(pad_present),
    .six_button(six_button), .valid(valid), .busy(busy)
  );

  always #5 clk = ~clk;

  // pad model: counts select low pulses, forgets them after a long high period
  always @(posedge clk) begin
    if (sel_q && !select) low_n <= low_n + 1;
    hi_cnt <= select ? hi_cnt + 1 : 0;
    if (select && hi_cnt >= 5) low_n <= 0;
    sel_q <= select;
  end

  always_comb begin
    {up_z, down_y, left_x, right, a_b, start_c} = 6'b111111;
    if (pad_type != 0) begin
      if (select) begin
        if (pad_type == 2 && low_n == 3)
          {up_z, down_y, left_x, right} = ~{held[0], held[1], held[2], 1'b0};
        else
          {up_z, down_y, left_x, right} = ~{held[10], held[9], held[8], held[7]};
        a_b = ~held[5];
        start_c = ~held[4];
      end else begin
        if (pad_type == 2 && low_n == 3)
          {up_z, down_y, left_x, right} = 4'b0000;
        else
          {up_z, down_y, left_x, right} = {~held[10], ~held[9], 2'b00};
        a_b = ~held[6];
        start_c = ~held[3];
      end
    end
  end

  task automatic poll_once();
    @(negedge clk) poll_req = 1'b1;
    @(posedge clk);
    #1 poll_req = 1'b0;
  endtask

  task automatic wait_valid(output int e);
    e = 0;
    while (!valid && e < 60) begin
      @(posedge clk);
      #1 e++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    tests++; if (select !== 1'b1) begin fails++; $display("FAIL reset_select got %b exp 1", select); end
    tests++; if (buttons !== 11'd0) begin fails++; $display("FAIL reset_buttons got %b exp 0", buttons); end
    tests++; if (pad_present !== 1'b0) begin fails++; $display("FAIL reset_present got %b exp 0", pad_present); end
    tests++; if (six_button !== 1'b0) begin fails++; $display("FAIL reset_six got %b exp 0", six_button); end
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
  endtask

  task automatic test_auto_scan();
    logic es;
    pad_type = 1;
    held = 11'b10000001000;
    @(negedge clk) reset = 1'b1;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk);
      #1;
      es = (n >= 256 && n <= 287) ? !(((n - 256) / 4) % 2) : 1'b1;
      tests++; if (select !== es) begin fails++; $display("FAIL auto_select n=%0d got %b exp %b", n, select, es); end
      tests++; if (valid !== (n == 289)) begin fails++; $display("FAIL auto_valid n=%0d got %b exp %b", n, valid, n == 289); end
      tests++; if (busy !== (n >= 256 && n <= 288)) begin fails++; $display("FAIL auto_busy n=%0d got %b", n, busy); end
      if (n == 288) begin
        tests++; if (buttons !== 11'd0) begin fails++; $display("FAIL auto_partial got %b exp 0", buttons); end
      end
      if (n == 289) begin
        tests++; if (buttons !== 11'b10000001000) begin fails++; $display("FAIL auto_buttons got %b exp 10000001000", buttons); end
        tests++; if (pad_present !== 1'b1) begin fails++; $display("FAIL auto_present got %b exp 1", pad_present); end
        tests++; if (six_button !== 1'b0) begin fails++; $display("FAIL auto_six got %b exp 0", six_button); end
      end
    end
  endtask

  task automatic test_six_button();
    int e;
    pad_type = 2;
    held = 11'b00000000101;
    poll_once();
    wait_valid(e);
    tests++; if (e !== 33) begin fails++; $display("FAIL six_latency got %0d exp 33", e); end
    tests++; if (buttons !== 11'b00000000101) begin fails++; $display("FAIL six_buttons got %b exp 00000000101", buttons); end
    tests++; if (pad_present !== 1'b1) begin fails++; $display("FAIL six_present got %b exp 1", pad_present); end
    tests++; if (six_button !== 1'b1) begin fails++; $display("FAIL six_flag got %b exp 1", six_button); end
  endtask

  task automatic test_no_pad();
    int e;
    pad_type = 0;
    held = 11'b11111111111;
    poll_once();
    wait_valid(e);
    tests++; if (e !== 33) begin fails++; $display("FAIL nopad_latency got %0d exp 33", e); end
    tests++; if (buttons !== 11'd0) begin fails++; $display("FAIL nopad_buttons got %b exp 0", buttons); end
    tests++; if (pad_present !== 1'b0) begin fails++; $display("FAIL nopad_present got %b exp 0", pad_present); end
    tests++; if (six_button !== 1'b0) begin fails++; $display("FAIL nopad_six got %b exp 0", six_button); end
  endtask

  task automatic test_back_to_back();
    logic ev;
    pad_type = 1;
    held = 11'b00011000000;
    poll_once();
    for (int e = 1; e <= 360; e++) begin
      @(posedge clk);
      #1 poll_req = (e == 5 || e == 15);
      ev = (e == 33 || e == 67 || e == 356);
      tests++; if (valid !== ev) begin fails++; $display("FAIL b2b_valid e=%0d got %b exp %b", e, valid, ev); end
      if (e == 33) begin
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_gap_busy got %b exp 0", busy); end
      end
      if (e == 34) begin
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_restart_busy got %b exp 1", busy); end
      end
      if (e == 67) begin
        tests++; if (buttons !== 11'b00011000000) begin fails++; $display("FAIL b2b_buttons got %b exp 00011000000", buttons); end
      end
    end
    poll_req = 1'b0;
  endtask

  task automatic test_reset_mid_scan();
    logic es;
    pad_type = 1;
    held = 11'b10000001000;
    poll_once();
    repeat (13) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    tests++; if (select !== 1'b1) begin fails++; $display("FAIL midrst_select got %b exp 1", select); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy got %b exp 0", busy); end
    tests++; if (buttons !== 11'd0) begin fails++; $display("FAIL midrst_buttons got %b exp 0", buttons); end
    tests++; if (pad_present !== 1'b0) begin fails++; $display("FAIL midrst_present got %b exp 0", pad_present); end
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL midrst_valid got %b exp 0", valid); end
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk);
      #1;
      es = (n >= 256 && n <= 287) ? !(((n - 256) / 4) % 2) : 1'b1;
      tests++; if (select !== es) begin fails++; $display("FAIL midrst_sel n=%0d got %b exp %b", n, select, es); end
      tests++; if (valid !== (n == 289)) begin fails++; $display("FAIL midrst_pulse n=%0d got %b exp %b", n, valid, n == 289); end
    end
  endtask

  initial begin
    test_reset();
    test_auto_scan();
    test_six_button();
    test_no_pad();
    test_back_to_back();
    test_reset_mid_scan();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/genesis_pad_sequencer.md
GENESIS_PAD_SEQUENCER -- requirements
Module: genesis_pad_sequencer

Interface
REQ-001 Parameter PHASE_CYCLES, default 100; clock cycles each select half-phase is held (2 us at 50 MHz).
REQ-002 Parameter PERIOD_LOG2, default 20; an automatic scan starts every 2^PERIOD_LOG2 cycles (about 20.97 ms at 50 MHz).
REQ-003 clk  input  1  system clock; all logic rising-edge.
REQ-004 reset  input  1  asynchronous active-low reset.
REQ-005 up_z, down_y, left_x, right, a_b, start_c  input  1 each  raw pad pins; active-low, so 0 means pressed or asserted.
REQ-006 poll_req  input  1  single-cycle request for an immediate scan.
REQ-007 select  output  1  pad select line.
REQ-008 buttons  output  11  active-high pressed map: [10]=up [9]=down [8]=left [7]=right [6]=A [5]=B [4]=C [3]=start [2]=X [1]=Y [0]=Z.
REQ-009 pad_present  output  1  a pad was detected in the last scan.
REQ-010 six_button  output  1  the last scan identified a 6-button pad.
REQ-011 valid  output  1  one-cycle pulse when buttons, pad_present and six_button update.
REQ-012 busy  output  1  high while a scan is in progress.

Function
REQ-013 FSM states: IDLE, SCAN, COMMIT.
REQ-014 IDLE: select=1; the period counter increments each cycle; on wrap to 0, or on poll_req/pending, the FSM goes to SCAN with phase=0.
REQ-015 SCAN: 8 phases, 0..7, each held exactly PHASE_CYCLES cycles; select=1 on even phases and 0 on odd phases.
REQ-016 Pins are sampled only on the last cycle of a phase, after select has been stable for PHASE_CYCLES-1 cycles.
REQ-017 Phase 0 captures up, down, left, right, B (a_b) and C (start_c).
REQ-018 Phase 1 captures A (a_b) and start (start_c); left_x=0 and right=0 at this sample sets the present flag.
REQ-019 Phase 5: up_z=down_y=left_x=right=0 at sample sets the six flag.
REQ-020 Phase 6 captures Z (up_z), Y (down_y) and X (left_x); the mode bit (right) is discarded.
REQ-021 Phases 2, 3, 4 and 7 are timing-only; nothing is captured.
REQ-022 After phase 7 the FSM enters COMMIT for 1 cycle, then returns to IDLE.
REQ-023 COMMIT: buttons, pad_present and six_button load atomically and valid=1; at all other times valid=0.
REQ-024 If present=0, buttons commit as all zero and six_button=0.
REQ-025 If six=0, bits [2:0] commit as 0.
REQ-026 Scan latency from leaving IDLE to the valid pulse is 8*PHASE_CYCLES+1 cycles.
REQ-027 buttons must never expose partially captured data.
REQ-028 busy=1 in SCAN and COMMIT.
REQ-029 poll_req while busy sets a 1-bit pending flag; further requests while pending is set are merged into it.
REQ-030 Pending starts a new scan on the cycle after COMMIT.
REQ-031 A period wrap occurring while busy is dropped; it is not queued.
REQ-032 Entering SCAN from either trigger clears the period counter.
REQ-033 poll_req and a period wrap in the same IDLE cycle start exactly one scan.
REQ-034 The period counter is PERIOD_LOG2 bits wide and wraps naturally.
REQ-035 The phase counter is 3 bits; the per-phase counter is clog2(PHASE_CYCLES) bits.

Reset
REQ-036 Reset asserted forces IDLE immediately, regardless of clk.
REQ-037 Reset values: select=1, buttons=0, pad_present=0, six_button=0, valid=0, busy=0, pending=0, all counters 0.
REQ-038 Reset mid-scan discards the partial capture and produces no valid pulse.
REQ-039 After reset release the first automatic scan starts 2^PERIOD_LOG2 cycles later, unless poll_req arrives first.

Structure
REQ-040 Shared package pad_pkg holds: the FSM state enum, the button bit-index constants, and the default PHASE_CYCLES and PERIOD_LOG2 values.
REQ-041 One sub-module, pad_phase_timer, implements the per-phase counter and the phase index, and outputs a sample strobe and a phase-done strobe.
REQ-042 No other hierarchy.

Verification
REQ-043 Parameters for all scenarios: PHASE_CYCLES=4, PERIOD_LOG2=8; the bench models a pad whose pin levels follow select.
REQ-044 Reset, then wait 256 cycles -> select toggles H,L eight times at 4 cycles each; valid pulses at cycle 256+33.
REQ-045 3-button pad with up and start held -> buttons=11'b10000001000, pad_present=1, six_button=0.
REQ-046 6-button pad with X and Z held (phase-5 pins all 0) -> buttons=11'b00000000101, six_button=1.
REQ-047 No pad (all pins 1) -> buttons=0, pad_present=0, valid still pulses.
REQ-048 poll_req pulsed twice during a scan -> exactly one extra scan starts the cycle after COMMIT; the period counter restarts.
REQ-049 Reset deasserted-asserted during phase 3 -> select=1 immediately, no valid pulse, outputs 0; the next scan starts 256 cycles after release.
